key_step_ctrl: RTL and testbench

KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

---
 rtl/key_step_ctrl_pkg.sv | 30 +++
 rtl/key_step_ctrl_run_divider.sv | 40 ++++
 rtl/key_step_ctrl.sv | 128 ++++++++++++
 tb/tb_key_step_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_step_ctrl_pkg.sv
// Shared encodings for the key-driven CPU step/run controller and its display consumers.
// Holds state and key-index constants plus the page-advance helper.
package key_step_ctrl_pkg;

    localparam int DIV_W  = 24;
    localparam int HOLD_W = 8;
    localparam int PAGE_W = 3;
    localparam int CNT_W  = 16;

    localparam int KEY_STEP = 0;
    localparam int KEY_RUN  = 1;
    localparam int KEY_PAGE = 2;
    localparam int KEY_CRST = 3;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        CRST  = 2'd3
    } state_e;

    function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] cur,
                                                    input int pages);
        if (int'(cur) >= pages - 1) begin
            return '0;
        end
        return cur + 3'd1;
    endfunction

endpackage

// File: rtl/key_step_ctrl_run_divider.sv
// Terminal-count counter producing the RUN-mode CPU tick every LIMIT enabled cycles.
// Supports synchronous clear and parallel load; tc_o is combinational on the held count.
module run_divider
    import key_step_ctrl_pkg::*;
#(
    parameter logic [DIV_W-1:0] LIMIT = 24'd5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == LIMIT - 24'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_step_ctrl.sv
// Front-panel controller: single-step, free-run and CPU-reset sequencing from debounced keys,
// plus an independent display page selector. Every output comes straight from a flop.
module key_step_ctrl
    import key_step_ctrl_pkg::*;
#(
    parameter logic [DIV_W-1:0]  RUN_DIV  = 24'd5000000,
    parameter logic [HOLD_W-1:0] RST_HOLD = 8'd16,
    parameter int                PAGES    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        key_pulse,
    input  logic              halt_req,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic [1:0]        mode,
    output logic [PAGE_W-1:0] page,
    output logic [CNT_W-1:0]  step_cnt
);

    state_e              state_q, state_d;
    logic                boot_q;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                cpu_en_q, cpu_en_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
    logic                div_clr;
    logic                div_tc;
    logic                in_run;

    assign in_run = (state_q == RUN);

    run_divider #(
        .LIMIT(RUN_DIV)
    ) u_run_divider (
        .clk        (clk),
        .rst        (rst),
        .en_i       (in_run),
        .clr_i      (div_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_o       (div_tc)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cpu_en_d    = 1'b0;
        cpu_rst_n_d = cpu_rst_n_q;
        step_cnt_d  = step_cnt_q;
        div_clr     = 1'b0;
        page_d      = key_pulse[KEY_PAGE] ? next_page(page_q, PAGES) : page_q;

        // The first clock after rst release behaves like a CPU-reset key press.
        if (boot_q || key_pulse[KEY_CRST]) begin
            state_d     = CRST;
            hold_d      = RST_HOLD;
            cpu_rst_n_d = 1'b0;
        end else begin
            case (state_q)
                PAUSE: begin
                    if (key_pulse[KEY_RUN] && !halt_req) begin
                        state_d = RUN;
                        div_clr = 1'b1;
                    end else if (key_pulse[KEY_STEP]) begin
                        state_d  = STEP;
                        cpu_en_d = 1'b1;
                    end
                end
                RUN: begin
                    if (halt_req || key_pulse[KEY_RUN]) begin
                        state_d = PAUSE;
                    end else if (div_tc) begin
                        cpu_en_d = 1'b1;
                    end
                end
                STEP: begin
                    state_d = PAUSE;
                end
                CRST: begin
                    if (hold_q > 8'd1) begin
                        hold_d = hold_q - 8'd1;
                    end else begin
                        state_d     = PAUSE;
                        hold_d      = '0;
                        cpu_rst_n_d = 1'b1;
                        step_cnt_d  = '0;
                    end
                end
                default: begin
                    state_d = PAUSE;
                end
            endcase
        end

        if (cpu_en_d && (step_cnt_q != 16'hFFFF)) begin
            step_cnt_d = step_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PAUSE;
            boot_q      <= 1'b1;
            hold_q      <= '0;
            cpu_en_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            page_q      <= '0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            boot_q      <= 1'b0;
            hold_q      <= hold_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            page_q      <= page_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign mode      = state_q;
    assign cpu_en    = cpu_en_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign page      = page_q;
    assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Self-checking bench for key_step_ctrl: directed scenarios plus randomized keys against a
// cycle-level behavioural model; a second instance covers PAGES=5 and step_cnt saturation.
module tb_key_step_ctrl;

    localparam int RUN_DIV_A  = 4;
    localparam int RST_HOLD_A = 3;
    localparam int PAGES_A    = 8;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic [3:0]  kp_a = 4'b0;
    logic [3:0]  kp_b = 4'b0;
    logic        halt_a = 1'b0;
    logic        halt_b = 1'b0;

    logic        en_a, rstn_a, en_b, rstn_b;
    logic [1:0]  mode_a, mode_b;
    logic [2:0]  page_a, page_b;
    logic [15:0] steps_a, steps_b;

    int checks = 0;
    int errors = 0;

    // Behavioural model state for instance A
    int m_mode, m_en, m_rstn, m_page, m_steps, m_div, m_hold, m_boot;

    always #5 clk = ~clk;

    key_step_ctrl #(.RUN_DIV(24'd4), .RST_HOLD(8'd3), .PAGES(8)) dut_a (
        .clk(clk), .rst(rst_a), .key_pulse(kp_a), .halt_req(halt_a),
        .cpu_en(en_a), .cpu_rst_n(rstn_a), .mode(mode_a), .page(page_a), .step_cnt(steps_a)
    );

    key_step_ctrl #(.RUN_DIV(24'd1), .RST_HOLD(8'd2), .PAGES(5)) dut_b (
        .clk(clk), .rst(rst_b), .key_pulse(kp_b), .halt_req(halt_b),
        .cpu_en(en_b), .cpu_rst_n(rstn_b), .mode(mode_b), .page(page_b), .step_cnt(steps_b)
    );

    task automatic model_reset();
        m_mode = 0; m_en = 0; m_rstn = 0; m_page = 0;
        m_steps = 0; m_div = 0; m_hold = 0; m_boot = 1;
    endtask

    // One clock of the controller described as: elapsed RUN cycles, remaining reset cycles.
    task automatic model_a(input logic [3:0] kp, input logic h);
        int en;
        en = 0;
        if (m_boot != 0 || kp[3]) begin
            m_mode = 3; m_hold = RST_HOLD_A; m_rstn = 0;
        end else if (m_mode == 0) begin
            if (kp[1] && !h) begin
                m_mode = 1; m_div = 0;
            end else if (kp[0]) begin
                m_mode = 2; en = 1;
            end
        end else if (m_mode == 1) begin
            if (h || kp[1]) begin
                m_mode = 0;
            end else begin
                m_div++;
                if (m_div == RUN_DIV_A) begin
                    m_div = 0; en = 1;
                end
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else begin
            m_hold--;
            if (m_hold <= 0) begin
                m_mode = 0; m_rstn = 1; m_steps = 0;
            end
        end
        m_boot = 0;
        m_en = en;
        if (en != 0 && m_steps < 65535) m_steps++;
        if (kp[2]) m_page = (m_page + 1) % PAGES_A;
    endtask

    task automatic tick_a(input logic [3:0] kp, input logic h);
        kp_a = kp; halt_a = h;
        model_a(kp, h);
        @(posedge clk); #1;
        kp_a = 4'b0; halt_a = 1'b0;
    endtask

    task automatic tick_b(input logic [3:0] kp, input logic h);
        kp_b = kp; halt_b = h;
        @(posedge clk); #1;
        kp_b = 4'b0; halt_b = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mode_a, en_a, rstn_a, page_a, steps_a} !== 23'd0) begin
            errors++;
            $display("FAIL reset_values got mode=%0d en=%0d rstn=%0d page=%0d steps=%0d want all 0",
                     mode_a, en_a, rstn_a, page_a, steps_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            tick_a(4'b0, 1'b0);
            checks++;
            if (rstn_a !== 1'b0 || mode_a !== 2'd3 || en_a !== 1'b0) begin
                errors++;
                $display("FAIL boot_hold cyc%0d got rstn=%0d mode=%0d en=%0d want 0 3 0",
                         i, rstn_a, mode_a, en_a);
            end
        end
        tick_a(4'b0, 1'b0);
        checks++;
        if (rstn_a !== 1'b1 || mode_a !== 2'd0 || steps_a !== 16'd0) begin
            errors++;
            $display("FAIL boot_exit got rstn=%0d mode=%0d steps=%0d want 1 0 0",
                     rstn_a, mode_a, steps_a);
        end
    endtask

    task automatic test_step();
        for (int i = 1; i <= 3; i++) begin
            tick_a(4'b0001, 1'b0);
            checks++;
            if (en_a !== 1'b1 || mode_a !== 2'd2) begin
                errors++;
                $display("FAIL step_pulse%0d got en=%0d mode=%0d want 1 2", i, en_a, mode_a);
            end
            tick_a(4'b0, 1'b0);
            checks++;
            if (en_a !== 1'b0 || mode_a !== 2'd0) begin
                errors++;
                $display("FAIL step_return%0d got en=%0d mode=%0d want 0 0", i, en_a, mode_a);
            end
        end
        checks++;
        if (steps_a !== 16'd3) begin
            errors++;
            $display("FAIL step_count got %0d want 3", steps_a);
        end
    endtask

    task automatic test_run();
        int extra;
        tick_a(4'b0010, 1'b0);
        checks++;
        if (mode_a !== 2'd1 || en_a !== 1'b0) begin
            errors++;
            $display("FAIL run_entry got mode=%0d en=%0d want 1 0", mode_a, en_a);
        end
        for (int i = 1; i <= 12; i++) begin
            // Step key in RUN must be ignored.
            tick_a((i == 2 || i == 7) ? 4'b0001 : 4'b0000, 1'b0);
            checks++;
            if (en_a !== ((i % 4) == 0) || mode_a !== 2'd1) begin
                errors++;
                $display("FAIL run_tick cyc%0d got en=%0d mode=%0d want %0d 1",
                         i, en_a, mode_a, ((i % 4) == 0));
            end
        end
        tick_a(4'b0010, 1'b0);
        checks++;
        if (mode_a !== 2'd0 || en_a !== 1'b0) begin
            errors++;
            $display("FAIL run_exit got mode=%0d en=%0d want 0 0", mode_a, en_a);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick_a(4'b0, 1'b0);
            if (en_a === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || steps_a !== 16'd6) begin
            errors++;
            $display("FAIL run_after_pause got extra_en=%0d steps=%0d want 0 6", extra, steps_a);
        end
    endtask

    task automatic test_halt();
        tick_a(4'b0010, 1'b0);
        repeat (3) tick_a(4'b0, 1'b0);
        tick_a(4'b0, 1'b1);
        checks++;
        if (mode_a !== 2'd0 || en_a !== 1'b0 || steps_a !== 16'd6) begin
            errors++;
            $display("FAIL halt_at_tc got mode=%0d en=%0d steps=%0d want 0 0 6",
                     mode_a, en_a, steps_a);
        end
        tick_a(4'b0001, 1'b1);
        checks++;
        if (mode_a !== 2'd2 || en_a !== 1'b1 || steps_a !== 16'd7) begin
            errors++;
            $display("FAIL step_past_halt got mode=%0d en=%0d steps=%0d want 2 1 7",
                     mode_a, en_a, steps_a);
        end
        tick_a(4'b0010, 1'b1);
        checks++;
        if (mode_a !== 2'd0 || en_a !== 1'b0) begin
            errors++;
            $display("FAIL halt_blocks_run got mode=%0d en=%0d want 0 0", mode_a, en_a);
        end
    endtask

    task automatic test_crst();
        tick_a(4'b0010, 1'b0);
        repeat (3) tick_a(4'b0, 1'b0);
        tick_a(4'b1011, 1'b0);
        checks++;
        if (mode_a !== 2'd3 || en_a !== 1'b0 || rstn_a !== 1'b0) begin
            errors++;
            $display("FAIL crst_priority got mode=%0d en=%0d rstn=%0d want 3 0 0",
                     mode_a, en_a, rstn_a);
        end
        tick_a(4'b0011, 1'b0);
        tick_a(4'b1000, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            tick_a(4'b0, 1'b0);
            checks++;
            if (mode_a !== 2'd3 || rstn_a !== 1'b0 || en_a !== 1'b0) begin
                errors++;
                $display("FAIL crst_reload cyc%0d got mode=%0d rstn=%0d en=%0d want 3 0 0",
                         i, mode_a, rstn_a, en_a);
            end
        end
        tick_a(4'b0, 1'b0);
        checks++;
        if (mode_a !== 2'd0 || rstn_a !== 1'b1 || steps_a !== 16'd0) begin
            errors++;
            $display("FAIL crst_exit got mode=%0d rstn=%0d steps=%0d want 0 1 0",
                     mode_a, rstn_a, steps_a);
        end
    endtask

    task automatic test_page();
        for (int i = 1; i <= 9; i++) begin
            tick_a(4'b0100, 1'b0);
            checks++;
            if (page_a !== 3'(i % 8)) begin
                errors++;
                $display("FAIL page_wrap8 pulse%0d got %0d want %0d", i, page_a, i % 8);
            end
        end
    endtask

    task automatic test_async_reset();
        tick_a(4'b0010, 1'b0);
        repeat (3) tick_a(4'b0, 1'b0);
        #2 rst_a = 1'b0;
        #1;
        checks++;
        if ({mode_a, en_a, rstn_a, page_a, steps_a} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset_run got mode=%0d en=%0d rstn=%0d page=%0d steps=%0d want all 0",
                     mode_a, en_a, rstn_a, page_a, steps_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        model_reset();
        tick_a(4'b0, 1'b0);
        #2 rst_a = 1'b0;
        #1;
        checks++;
        if (mode_a !== 2'd0 || rstn_a !== 1'b0 || en_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_crst got mode=%0d rstn=%0d en=%0d want 0 0 0",
                     mode_a, rstn_a, en_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        model_reset();
        repeat (4) tick_a(4'b0, 1'b0);
        checks++;
        if (mode_a !== 2'd0 || rstn_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_recover got mode=%0d rstn=%0d want 0 1", mode_a, rstn_a);
        end
    endtask

    task automatic test_random();
        logic [3:0]  kp;
        logic        h;
        logic [22:0] expv;
        int          bad;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            kp[0] = ($urandom_range(0, 5) == 0);
            kp[1] = ($urandom_range(0, 7) == 0);
            kp[2] = ($urandom_range(0, 3) == 0);
            kp[3] = ($urandom_range(0, 60) == 0);
            h     = ($urandom_range(0, 9) == 0);
            tick_a(kp, h);
            expv = {2'(m_mode), 1'(m_en), 1'(m_rstn), 3'(m_page), 16'(m_steps)};
            checks++;
            if ({mode_a, en_a, rstn_a, page_a, steps_a} !== expv) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc%0d kp=%b h=%0d got mode=%0d en=%0d rstn=%0d page=%0d steps=%0d want %0d %0d %0d %0d %0d",
                             i, kp, h, mode_a, en_a, rstn_a, page_a, steps_a,
                             m_mode, m_en, m_rstn, m_page, m_steps);
            end
            checks++;
            if (en_a === 1'b1 && rstn_a !== 1'b1) begin
                errors++;
                $display("FAIL en_during_reset cyc%0d got en=1 rstn=%0d want en=0", i, rstn_a);
            end
        end
    endtask

    task automatic test_pages5_saturation();
        logic [3:0] kps [9];
        int         pgs [9];
        int         mds [9];
        kps = '{4'b0100, 4'b0110, 4'b0100, 4'b1100, 4'b0100, 4'b0100, 4'b0101, 4'b0100, 4'b0100};
        pgs = '{1, 2, 3, 4, 0, 1, 2, 3, 4};
        mds = '{0, 1, 1, 3, 3, 0, 2, 0, 0};
        @(negedge clk);
        rst_b = 1'b1;
        repeat (3) tick_b(4'b0, 1'b0);
        checks++;
        if (mode_b !== 2'd0 || rstn_b !== 1'b1) begin
            errors++;
            $display("FAIL b_boot got mode=%0d rstn=%0d want 0 1", mode_b, rstn_b);
        end
        for (int i = 0; i < 9; i++) begin
            tick_b(kps[i], 1'b0);
            checks++;
            if (page_b !== 3'(pgs[i]) || mode_b !== 2'(mds[i])) begin
                errors++;
                $display("FAIL page_wrap5 pulse%0d got page=%0d mode=%0d want %0d %0d",
                         i + 1, page_b, mode_b, pgs[i], mds[i]);
            end
        end
        tick_b(4'b1000, 1'b0);
        repeat (2) tick_b(4'b0, 1'b0);
        tick_b(4'b0010, 1'b0);
        for (int i = 1; i <= 65535; i++) begin
            tick_b(4'b0, 1'b0);
            if (i == 65534) begin
                checks++;
                if (steps_b !== 16'hFFFE) begin
                    errors++;
                    $display("FAIL sat_approach got %h want fffe", steps_b);
                end
            end
        end
        checks++;
        if (steps_b !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach got %h want ffff", steps_b);
        end
        repeat (3) tick_b(4'b0, 1'b0);
        checks++;
        if (steps_b !== 16'hFFFF || en_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold_run got steps=%h en=%0d want ffff 1", steps_b, en_b);
        end
        tick_b(4'b0010, 1'b0);
        tick_b(4'b0001, 1'b0);
        checks++;
        if (steps_b !== 16'hFFFF || en_b !== 1'b1 || mode_b !== 2'd2) begin
            errors++;
            $display("FAIL sat_step got steps=%h en=%0d mode=%0d want ffff 1 2",
                     steps_b, en_b, mode_b);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_step();
        test_run();
        test_halt();
        test_crst();
        test_page();
        test_async_reset();
        test_random();
        test_pages5_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
